// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux_8_1 select sequencer / sampler.
package mux_scan_pkg;

  localparam int unsigned NUM_IN = 8;
  localparam int unsigned SEL_W  = $clog2(NUM_IN);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable settle down-counter; expire flags the last settle cycle (count==1).
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/mux_8_1_scan_ctrl.sv
// Steps mux_8_1 selects 0..7, samples mux_out into an 8-bit word after each
// settle window, and hands the finished word out on a valid/ready port.
module mux_8_1_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              S0,
  output logic              S1,
  output logic              S2,
  input  logic              mux_out,
  output logic [NUM_IN-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_IN - 1);
  // With no settle window every select step goes straight to sampling.
  localparam scan_state_t FIRST_STEP = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  scan_state_t       state, state_nx;
  logic [SEL_W-1:0]  sel, sel_nx;
  logic [NUM_IN-1:0] shadow, shadow_nx, data_nx;
  logic              valid_nx;
  logic              cnt_load, cnt_dec, cnt_expire;

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_LD),
    .expire   (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      shadow  <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      shadow  <= shadow_nx;
      data_o  <= data_nx;
      valid_o <= valid_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    shadow_nx = shadow;
    data_nx   = data_o;
    valid_nx  = valid_o;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FIRST_STEP;
          sel_nx   = '0;
          cnt_load = 1'b1;
        end
      end
      SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_expire) state_nx = SAMPLE;
      end
      SAMPLE: begin
        shadow_nx[sel] = mux_out;
        if (sel == SEL_LAST) begin
          // Last bit bypasses the shadow so the word publishes this edge.
          data_nx      = shadow;
          data_nx[sel] = mux_out;
          valid_nx     = 1'b1;
          state_nx     = DONE;
        end else begin
          sel_nx   = sel + 1'b1;
          cnt_load = 1'b1;
          state_nx = FIRST_STEP;
        end
      end
      DONE: begin
        if (valid_o && ready_i) begin
          valid_nx = 1'b0;
          sel_nx   = '0;
          if (start) begin
            state_nx = FIRST_STEP;
            cnt_load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign {S2, S1, S0} = sel;
  assign busy_o       = (state == SETTLE) || (state == SAMPLE);

endmodule

// File: tb/tb_mux_8_1_scan_ctrl.sv
// Bench for mux_8_1_scan_ctrl at SETTLE_CYCLES = 1, 0 and 3 with a shared mux model.
module tb_mux_8_1_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] d = 8'h55;

  logic [2:0] s0, s1, s2, valid, busy, mo;
  logic [7:0] data [3];

  int checks = 0;
  int errors = 0;

  int rise [3];
  int nrise0;
  int rise2_0;

  always #5 clk = ~clk;

  assign mo[0] = d[{s2[0], s1[0], s0[0]}];
  assign mo[1] = d[{s2[1], s1[1], s0[1]}];
  assign mo[2] = d[{s2[2], s1[2], s0[2]}];

  mux_8_1_scan_ctrl #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .S0(s0[0]), .S1(s1[0]), .S2(s2[0]),
    .mux_out(mo[0]), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready), .busy_o(busy[0]));
  mux_8_1_scan_ctrl #(.SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .S0(s0[1]), .S1(s1[1]), .S2(s2[1]),
    .mux_out(mo[1]), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready), .busy_o(busy[1]));
  mux_8_1_scan_ctrl #(.SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .S0(s0[2]), .S1(s1[2]), .S2(s2[2]),
    .mux_out(mo[2]), .data_o(data[2]), .valid_o(valid[2]), .ready_i(ready), .busy_o(busy[2]));

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, k, act, exp);
    end
  endtask

  // Model: a scan is a timeline of 8*(settle+1) cycles; cycle t drives select
  // t/(settle+1) and the last cycle of each select period captures d[select].
  int         sc [3] = '{1, 0, 3};
  int         m_phase [3];   // 0 idle, 1 scanning, 2 word waiting
  int         m_t [3];
  logic [7:0] m_word [3];
  logic [7:0] m_data [3];
  logic       m_valid [3];
  int         p_m;
  logic [2:0] e_sel;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      p_m = sc[k] + 1;
      if (rst) begin
        m_phase[k] = 0; m_t[k] = 0; m_data[k] = 8'h00; m_valid[k] = 1'b0;
      end else if (m_phase[k] == 0) begin
        if (start) begin m_phase[k] = 1; m_t[k] = 0; end
      end else if (m_phase[k] == 1) begin
        if (m_t[k] % p_m == p_m - 1) m_word[k][m_t[k] / p_m] = d[m_t[k] / p_m];
        if (m_t[k] == 8 * p_m - 1) begin
          m_data[k] = m_word[k]; m_valid[k] = 1'b1; m_phase[k] = 2;
        end else begin
          m_t[k] = m_t[k] + 1;
        end
      end else if (ready) begin
        m_valid[k] = 1'b0;
        if (start) begin m_phase[k] = 1; m_t[k] = 0; end
        else m_phase[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      if (m_phase[k] == 1) e_sel = 3'(m_t[k] / (sc[k] + 1));
      else if (m_phase[k] == 2) e_sel = 3'd7;
      else e_sel = 3'd0;
      check("sel", k, {s2[k], s1[k], s0[k]}, e_sel);
      check("busy", k, busy[k], m_phase[k] == 1);
      check("valid", k, valid[k], m_valid[k]);
      check("data", k, data[k], m_data[k]);
    end
  end

  // Start sampled at edge 0; after loop iteration n the bench sits just past edge n.
  task automatic run(input bit hold, input int mid, input int rst_at, input int ncyc);
    logic [2:0] prev;
    for (int k = 0; k < 3; k++) rise[k] = -1;
    nrise0 = 0; rise2_0 = -1;
    start = 1'b1;
    @(negedge clk);
    prev = valid;
    for (int n = 1; n <= ncyc; n++) begin
      start = hold || (n == mid);
      rst   = (n == rst_at);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (valid[k] && !prev[k] && rise[k] < 0) rise[k] = n;
      if (valid[0] && !prev[0]) begin
        nrise0++;
        if (nrise0 == 2) rise2_0 = n;
      end
      prev = valid;
      if (n == rst_at) begin
        for (int k = 0; k < 3; k += 2) begin
          check("rst_sel", k, {s2[k], s1[k], s0[k]}, 0);
          check("rst_busy", k, busy[k], 0);
          check("rst_valid", k, valid[k], 0);
          check("rst_data", k, data[k], 8'h00);
        end
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_valid", k, valid[k], 0);
      check("reset_busy", k, busy[k], 0);
      check("reset_data", k, data[k], 8'h00);
      check("reset_sel", k, {s2[k], s1[k], s0[k]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single scan, consumer always ready.
    d = 8'h55; ready = 1'b1;
    run(1'b0, -1, -1, 40);
    check("t1_rise", 0, rise[0], 16);
    check("t1_rise", 1, rise[1], 8);
    check("t1_rise", 2, rise[2], 32);
    for (int k = 0; k < 3; k++) begin
      check("t1_data", k, data[k], 8'h55);
      check("t1_valid_clr", k, valid[k], 0);
    end

    // Consumer stalls; word and selects must hold until the handshake.
    ready = 1'b0;
    run(1'b0, -1, -1, 45);
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_valid", k, valid[k], 1);
      check("t2_hold_data", k, data[k], 8'h55);
      check("t2_hold_sel", k, {s2[k], s1[k], s0[k]}, 7);
    end
    ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("t2_ack_valid", k, valid[k], 0);
      check("t2_ack_busy", k, busy[k], 0);
      check("t2_ack_sel", k, {s2[k], s1[k], s0[k]}, 0);
    end

    // start mid-scan is ignored; a fresh start afterwards yields a new word.
    run(1'b0, 5, -1, 40);
    check("t3_words", 0, nrise0, 1);
    check("t3_rise", 0, rise[0], 16);
    run(1'b0, -1, -1, 40);
    check("t3_second_rise", 0, rise[0], 16);

    // Reset at cycle 9 aborts the scan; no word without a new start.
    run(1'b0, -1, 9, 40);
    check("t4_noword", 0, rise[0], -1);
    check("t4_noword", 2, rise[2], -1);
    check("t4_rise_before_rst", 1, rise[1], 8);

    // Back-to-back scans: handshake edge doubles as the next start edge.
    d = 8'hAA;
    run(1'b1, -1, -1, 50);
    check("t5_rise", 0, rise[0], 16);
    check("t5_rise2", 0, rise2_0, 33);
    repeat (40) @(negedge clk);
    check("t5_data", 0, data[0], 8'hAA);
    check("t5_idle_busy", 0, busy[0], 0);

    // Latency across settle settings.
    d = 8'hFF;
    run(1'b0, -1, -1, 40);
    check("t6_rise", 1, rise[1], 8);
    check("t6_data", 1, data[1], 8'hFF);
    check("t6_rise", 2, rise[2], 32);
    check("t6_data", 2, data[2], 8'hFF);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
